// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse-domain to game-domain crossing.
// POS_W           : default width of the x/y position buses.
// SYNC_STAGES_DEF : default flop count for toggle synchronisers.
// mouse_snap_t    : one coherent mouse snapshot, also used by the receiver.
package mouse_pkg;

  localparam int unsigned POS_W           = 12;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             left;
    logic             click;
  } mouse_snap_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser with synchronous active-high reset.
// Ports:
//   clk : destination clock
//   rst : synchronous reset, clears every stage to 0
//   d   : asynchronous input bit
//   q   : synchronised output, Stages cycles behind d
module sync_ff #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d};
    end
  end

  assign q = sync_q[Stages-1];

endmodule

// File: rtl/mouse_cdc_tx.sv
// Source half of a toggle req/ack handshake that moves mouse state from the
// mouse clock domain to the game clock domain. A snapshot is launched when the
// inputs differ from the held outputs or a press is pending; the snapshot and
// req_toggle_out then stay frozen until the synchronised ack matches req.
// Ports:
//   clk, rst         : mouse-domain clock, synchronous active-high reset
//   xpos_in/ypos_in  : raw position from MouseCtl
//   mouse_left_in    : raw left-button level
//   ack_toggle_in    : ack toggle from the destination (asynchronous)
//   xpos_out/ypos_out/mouse_left_out : held snapshot
//   click_out        : a press edge occurred since the previous snapshot
//   req_toggle_out   : request toggle to the destination
//   busy             : a transfer is awaiting its ack
module mouse_cdc_tx #(
  parameter int unsigned POS_W       = mouse_pkg::POS_W,
  parameter int unsigned SYNC_STAGES = mouse_pkg::SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] xpos_in,
  input  logic [POS_W-1:0] ypos_in,
  input  logic             mouse_left_in,
  input  logic             ack_toggle_in,
  output logic [POS_W-1:0] xpos_out,
  output logic [POS_W-1:0] ypos_out,
  output logic             mouse_left_out,
  output logic             click_out,
  output logic             req_toggle_out,
  output logic             busy
);

  import mouse_pkg::*;

  typedef enum logic {StIdle, StWaitAck} state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             left_q, left_d, click_q, click_d;
  logic             req_q, req_d, busy_q, busy_d;
  logic             pend_q, pend_d;
  logic             prev_left_q;
  logic             ack_sync;
  logic             press;
  logic             dirty;

  sync_ff #(
    .Stages(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (ack_toggle_in),
    .q  (ack_sync)
  );

  assign press = mouse_left_in & ~prev_left_q;
  assign dirty = (xpos_in != x_q) | (ypos_in != y_q) | (mouse_left_in != left_q) |
                 pend_q | press;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    left_d  = left_q;
    click_d = click_q;
    req_d   = req_q;
    busy_d  = busy_q;
    // A press is remembered until some launch carries it out.
    pend_d  = pend_q | press;
    case (state_q)
      StIdle: begin
        if (dirty) begin
          x_d     = xpos_in;
          y_d     = ypos_in;
          left_d  = mouse_left_in;
          click_d = pend_q | press;
          pend_d  = 1'b0;
          req_d   = ~req_q;
          busy_d  = 1'b1;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (ack_sync == req_q) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      left_q      <= 1'b0;
      click_q     <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      prev_left_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      left_q      <= left_d;
      click_q     <= click_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      prev_left_q <= mouse_left_in;
    end
  end

  assign xpos_out       = x_q;
  assign ypos_out       = y_q;
  assign mouse_left_out = left_q;
  assign click_out      = click_q;
  assign req_toggle_out = req_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mouse_cdc_tx.sv
module tb_mouse_cdc_tx;

  localparam int unsigned PW = 12;
  localparam int unsigned SS = 2;
  localparam int unsigned VW = 2 * PW + 4;
  localparam int unsigned WAIT_LIMIT = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] xpos_in = '0;
  logic [PW-1:0] ypos_in = '0;
  logic          mouse_left_in = 1'b0;
  logic          ack_toggle_in = 1'b0;
  logic [PW-1:0] xpos_out, ypos_out;
  logic          mouse_left_out, click_out, req_toggle_out, busy;

  int total = 0;
  int bad   = 0;

  // Reference model: the held snapshot, the handshake flags and the ack
  // history, with the synchroniser treated as a pure SS-cycle delay line.
  logic [PW-1:0] m_x = '0, m_y = '0;
  logic          m_left = 1'b0, m_click = 1'b0, m_req = 1'b0, m_busy = 1'b0;
  logic          m_pend = 1'b0, m_prev = 1'b0;
  bit            m_hist[$];

  wire [VW-1:0] act_v = {xpos_out, ypos_out, mouse_left_out, click_out, req_toggle_out, busy};
  wire [VW-1:0] exp_v = {m_x, m_y, m_left, m_click, m_req, m_busy};

  mouse_cdc_tx #(
    .POS_W      (PW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .xpos_in       (xpos_in),
    .ypos_in       (ypos_in),
    .mouse_left_in (mouse_left_in),
    .ack_toggle_in (ack_toggle_in),
    .xpos_out      (xpos_out),
    .ypos_out      (ypos_out),
    .mouse_left_out(mouse_left_out),
    .click_out     (click_out),
    .req_toggle_out(req_toggle_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the model from the inputs seen at this edge,
  // then let the edge happen and settle.
  task automatic tick();
    bit a;
    bit press;
    if (rst) begin
      m_x = '0; m_y = '0; m_left = 0; m_click = 0; m_req = 0; m_busy = 0;
      m_pend = 0; m_prev = 0;
      m_hist.delete();
      for (int i = 0; i < int'(SS); i++) m_hist.push_back(1'b0);
    end else begin
      a = m_hist.pop_front();
      m_hist.push_back(ack_toggle_in);
      press  = mouse_left_in && !m_prev;
      m_prev = mouse_left_in;
      if (!m_busy) begin
        if (xpos_in != m_x || ypos_in != m_y || mouse_left_in != m_left || m_pend || press) begin
          m_x = xpos_in; m_y = ypos_in; m_left = mouse_left_in;
          m_click = m_pend | press;
          m_pend  = 0;
          m_req   = ~m_req;
          m_busy  = 1;
        end
      end else begin
        m_pend = m_pend | press;
        if (a == m_req) m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; xpos_in = 12'h123; ypos_in = '0; mouse_left_in = 1'b0; ack_toggle_in = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if (act_v !== '0) begin
        bad++;
        $display("FAIL reset_outputs actual=%h required=0", act_v);
      end
    end
    xpos_in = '0; ack_toggle_in = 1'b0; rst = 1'b0;
    tick();
    total++;
    if (act_v !== '0 || act_v !== exp_v) begin
      bad++;
      $display("FAIL reset_release_quiet actual=%h required=%h", act_v, exp_v);
    end
  endtask

  task automatic test_single();
    int n;
    xpos_in = 12'd100; ypos_in = 12'd200;
    tick();
    total++;
    if ({xpos_out, ypos_out, req_toggle_out, busy} !== {12'd100, 12'd200, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL single_launch actual=%h required=%h",
               {xpos_out, ypos_out, req_toggle_out, busy}, {12'd100, 12'd200, 1'b1, 1'b1});
    end
    ack_toggle_in = 1'b1;
    n = 0;
    while (busy && n < int'(WAIT_LIMIT)) begin
      tick();
      n++;
    end
    total++;
    if (n != int'(SS) + 1) begin
      bad++;
      $display("FAIL single_ack_latency actual=%0d required=%0d", n, SS + 1);
    end
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL single_after_ack actual=%h required=%h", act_v, exp_v);
    end
  endtask

  task automatic test_hold();
    int n;
    ypos_in = 12'd201;
    tick();
    total++;
    if ({xpos_out, ypos_out, req_toggle_out, busy} !== {12'd100, 12'd201, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL hold_launch actual=%h required=%h",
               {xpos_out, ypos_out, req_toggle_out, busy}, {12'd100, 12'd201, 1'b0, 1'b1});
    end
    for (int v = 101; v <= 110; v++) begin
      xpos_in = PW'(v);
      tick();
      total++;
      if ({xpos_out, req_toggle_out, busy} !== {12'd100, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL hold_frozen actual=%h required=%h",
                 {xpos_out, req_toggle_out, busy}, {12'd100, 1'b0, 1'b1});
      end
    end
    ack_toggle_in = 1'b0;
    n = 0;
    while (busy && n < int'(WAIT_LIMIT)) begin
      tick();
      n++;
    end
    tick();
    total++;
    if ({xpos_out, req_toggle_out, busy} !== {12'd110, 1'b1, 1'b1} || act_v !== exp_v) begin
      bad++;
      $display("FAIL hold_latest_sent actual=%h required=%h", act_v, exp_v);
    end
  endtask

  task automatic test_click();
    int n;
    mouse_left_in = 1'b1;
    tick();
    tick();
    mouse_left_in = 1'b0;
    tick();
    total++;
    if ({mouse_left_out, click_out, busy} !== {1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL click_frozen actual=%b required=001", {mouse_left_out, click_out, busy});
    end
    ack_toggle_in = 1'b1;
    n = 0;
    while (busy && n < int'(WAIT_LIMIT)) begin
      tick();
      n++;
    end
    tick();
    total++;
    if ({mouse_left_out, click_out, req_toggle_out, busy} !== 4'b0101 || act_v !== exp_v) begin
      bad++;
      $display("FAIL click_carried actual=%h required=%h", act_v, exp_v);
    end
    ack_toggle_in = 1'b0;
    n = 0;
    while (busy && n < int'(WAIT_LIMIT)) begin
      tick();
      n++;
    end
    xpos_in = 12'd55;
    tick();
    total++;
    if ({xpos_out, click_out, req_toggle_out, busy} !== {12'd55, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL click_cleared actual=%h required=%h",
               {xpos_out, click_out, req_toggle_out, busy}, {12'd55, 1'b0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_idle_quiet();
    int n;
    ack_toggle_in = 1'b1;
    n = 0;
    while (busy && n < int'(WAIT_LIMIT)) begin
      tick();
      n++;
    end
    for (int i = 0; i < 40; i++) begin
      ack_toggle_in = 1'($urandom_range(0, 1));
      tick();
      total++;
      if ({req_toggle_out, busy} !== 2'b10 || act_v !== exp_v) begin
        bad++;
        $display("FAIL idle_quiet actual=%h required=%h", act_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    xpos_in = 12'd77;
    tick();
    ack_toggle_in = 1'b0;
    n = 0;
    while (busy && n < int'(WAIT_LIMIT)) begin
      tick();
      n++;
    end
    xpos_in = 12'd78;
    tick();
    total++;
    if ({xpos_out, req_toggle_out, busy} !== {12'd78, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL midrst_setup actual=%h required=%h",
               {xpos_out, req_toggle_out, busy}, {12'd78, 1'b1, 1'b1});
    end
    rst = 1'b1;
    tick();
    total++;
    if (act_v !== '0) begin
      bad++;
      $display("FAIL midrst_cleared actual=%h required=0", act_v);
    end
    xpos_in = '0; ypos_in = '0; rst = 1'b0;
    tick();
    xpos_in = 12'd9;
    tick();
    total++;
    if ({xpos_out, ypos_out, req_toggle_out, busy} !== {12'd9, 12'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL midrst_relaunch actual=%h required=%h",
               {xpos_out, ypos_out, req_toggle_out, busy}, {12'd9, 12'd0, 1'b1, 1'b1});
    end
  endtask

  // Random traffic against an emulated destination that echoes req after a
  // random delay.
  task automatic test_random();
    int dly = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) xpos_in = PW'($urandom);
      if ($urandom_range(0, 5) == 0) ypos_in = PW'($urandom);
      if ($urandom_range(0, 4) == 0) mouse_left_in = ~mouse_left_in;
      if (ack_toggle_in !== req_toggle_out) begin
        if (dly == 0) ack_toggle_in = req_toggle_out;
        else dly--;
      end else begin
        dly = int'($urandom_range(0, 4));
      end
      tick();
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL random_cycle%0d actual=%h required=%h", i, act_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_click();
    test_idle_quiet();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
